hack_rom_boot_sequencer: RTL
============================

Name: hack_rom_boot_sequencer

Overview:
Boot-time controller that streams a Hack program from a byte source (UART/SPI flash front-end) into the SoC ROM through the rom_loader handshake. It assembles byte pairs into 16-bit instructions and sequences rom_loader_reset, load, ack and load_received for each word. It holds hack_external_reset asserted until the whole image is written, then releases the CPU. It sits beside hack_soc and replaces the simulation-only file loader on silicon and FPGA builds.

Parameters:
DATA_WIDTH, 16, instruction width driven on rom_loader_data (fixed two bytes per word)
COUNT_WIDTH, 16, width of word_count and words_loaded
ACK_TIMEOUT, 4096, max cycles spent in LOAD plus WAIT_ACK for one word before ERROR
RELEASE_HOLD, 4, cycles hack_external_reset stays high after the last ack

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets)
start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERROR
word_count  in  COUNT_WIDTH  number of instructions to load; latched on accepted start
byte_in  in  8  incoming image byte
byte_valid  in  1  byte_in valid
byte_ready  out  1  sequencer accepts byte; transfer = byte_valid & byte_ready
rom_loader_reset  out  1  one-cycle pulse that rewinds the SoC loader address to 0
rom_loader_load  out  1  write request for rom_loader_data
rom_loader_data  out  DATA_WIDTH  instruction word
rom_loader_load_received  in  1  SoC has captured the request
rom_loader_ack  in  1  SoC write complete
hack_external_reset  out  1  holds the Hack CPU in reset
busy  out  1  high in every state except IDLE, DONE, ERROR
done  out  1  high in DONE
error  out  1  high in ERROR
words_loaded  out  COUNT_WIDTH  words acknowledged in the current load

Behaviour:
- All outputs registered. On reset==0: state IDLE, hack_external_reset=1, every other output 0 (data and words_loaded included).
- States: IDLE, LDR_RST, GET_HI, GET_LO, LOAD, WAIT_ACK, RELEASE, DONE, ERROR.
- IDLE/DONE/ERROR with start=1: latch word_count, clear words_loaded, go to LDR_RST. hack_external_reset=1 and done/error=0 from the next cycle.
- start is ignored while busy.
- LDR_RST: rom_loader_reset=1 for exactly one cycle. Next state is GET_HI, or RELEASE if latched count==0.
- GET_HI: byte_ready=1. On transfer, byte_in goes to data[15:8] and the state moves to GET_LO. MSB-first.
- GET_LO: byte_ready=1. On transfer, byte_in goes to data[7:0] and the state moves to LOAD.
- byte_ready is 0 in every other state. Back-to-back bytes give one byte per cycle.
- LOAD: rom_loader_load=1. rom_loader_data stays stable from LOAD entry until the word's ack.
  - load_received sampled 1: load drops next cycle, state goes to WAIT_ACK.
  - load_received and ack sampled 1 in the same cycle: word complete, WAIT_ACK is skipped.
- WAIT_ACK: load=0, data held. When ack is sampled 1, words_loaded increments by 1 the next cycle. Then go to RELEASE if the new value == latched count, else GET_HI.
- Timeout: counter cleared on LOAD entry, runs through LOAD and WAIT_ACK. When it reaches ACK_TIMEOUT, go to ERROR with load=0. hack_external_reset stays 1 and words_loaded is frozen.
- RELEASE: hack_external_reset=1 for RELEASE_HOLD cycles, then DONE.
- DONE: hack_external_reset=0, done=1. Stray ack/load_received and byte_valid are ignored.
- ERROR: error=1, CPU held in reset. Only start or reset leaves ERROR.
- reset==0 mid-load: immediate IDLE next edge, load deasserted, partial image abandoned. The next start re-pulses rom_loader_reset.
- word_count latched at start; later changes have no effect until the next start. words_loaded wraps never (compare is equality on latched count).

Test Plan:
- Reset then release reset, no start -> hack_external_reset=1, byte_ready=0, busy=0, words_loaded=0 held indefinitely.
- start, word_count=3, bytes 0x00,0x05,0xEC,0x10,0xE3,0x08 always valid, SoC acks 2 cycles after load -> one rom_loader_reset pulse. Words 0x0005, 0xEC10, 0xE308 loaded in order. words_loaded=3. hack_external_reset falls exactly RELEASE_HOLD cycles after the third ack, done=1.
- Same-cycle load_received+ack, plus byte_valid gaps of 0..5 cycles -> no WAIT_ACK cycle. Data is stable while load=1. Sequence completes with correct words.
- word_count=0 -> rom_loader_reset pulse, no load, no byte_ready. done=1 after RELEASE_HOLD cycles.
- Withhold ack on word 2 (ACK_TIMEOUT=16) -> error=1 after 16 cycles, load=0, words_loaded=1, hack_external_reset=1. A new start restarts from rom_loader_reset.
- reset=0 during GET_LO of word 1, then start again -> outputs return to reset values. Restart loads from word 0. start pulsed while busy is ignored.

Source files
------------

// File: rtl/hack_rom_boot_sequencer.sv
// -----------------------------------------------------------------------------
// hack_rom_boot_sequencer
//
// Boot-time controller that streams a Hack program image from a byte source
// (UART / SPI-flash front-end) into the SoC instruction ROM through the
// rom_loader handshake, then releases the Hack CPU from reset.
//
// Each instruction arrives as two bytes, most significant byte first. Every
// word is presented on rom_loader_data with rom_loader_load high until the SoC
// reports load_received; the word is complete once rom_loader_ack is seen
// (either together with load_received or later). A watchdog bounds the time
// spent on one word. After the last word the CPU is kept in reset for a few
// more cycles before DONE.
//
// Ports
//   clk                       system clock
//   reset                     synchronous reset, active low
//   start                     one-cycle pulse, starts a load from IDLE/DONE/ERROR
//   word_count                number of instructions, captured on accepted start
//   byte_in / byte_valid      image byte stream
//   byte_ready                byte accepted when byte_valid & byte_ready
//   rom_loader_reset          one-cycle pulse rewinding the SoC load address
//   rom_loader_load           write request for rom_loader_data
//   rom_loader_data           instruction word, stable from request to ack
//   rom_loader_load_received  SoC has captured the request
//   rom_loader_ack            SoC has completed the write
//   hack_external_reset       holds the Hack CPU in reset
//   busy / done / error       status; busy outside IDLE, DONE and ERROR
//   words_loaded              words acknowledged during the current load
// -----------------------------------------------------------------------------
module hack_rom_boot_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int COUNT_WIDTH  = 16,
  parameter int ACK_TIMEOUT  = 4096,
  parameter int RELEASE_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   rom_loader_reset,
  output logic                   rom_loader_load,
  output logic [DATA_WIDTH-1:0]  rom_loader_data,
  input  logic                   rom_loader_load_received,
  input  logic                   rom_loader_ack,
  output logic                   hack_external_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] words_loaded
);

  // The watchdog counts 0 .. ACK_TIMEOUT-1, the release counter
  // 0 .. RELEASE_HOLD-1; both need at least one bit.
  localparam int TMR_W  = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;
  localparam int HOLD_W = (RELEASE_HOLD > 1) ? $clog2(RELEASE_HOLD) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RELEASE_HOLD - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LDR_RST,
    S_GET_HI,
    S_GET_LO,
    S_LOAD,
    S_WAIT_ACK,
    S_RELEASE,
    S_DONE,
    S_ERROR
  } state_t;

  // Every single-bit output is a pure function of the state it belongs to.
  typedef struct packed {
    logic byte_ready;
    logic ldr_reset;
    logic load;
    logic cpu_reset;
    logic busy;
    logic done;
    logic error;
  } flags_t;

  function automatic flags_t flags_for(input state_t s);
    flags_t f;
    f            = '0;
    f.byte_ready = (s == S_GET_HI) || (s == S_GET_LO);
    f.ldr_reset  = (s == S_LDR_RST);
    f.load       = (s == S_LOAD);
    // The CPU only runs once the complete image is in ROM.
    f.cpu_reset  = (s != S_DONE);
    f.busy       = !(s inside {S_IDLE, S_DONE, S_ERROR});
    f.done       = (s == S_DONE);
    f.error      = (s == S_ERROR);
    return f;
  endfunction

  state_t                 state;
  flags_t                 flags;
  logic [COUNT_WIDTH-1:0] count_latched;
  logic [COUNT_WIDTH-1:0] words_next;
  logic [TMR_W-1:0]       timer;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   xfer;
  logic                   word_acked;

  assign byte_ready          = flags.byte_ready;
  assign rom_loader_reset    = flags.ldr_reset;
  assign rom_loader_load     = flags.load;
  assign hack_external_reset = flags.cpu_reset;
  assign busy                = flags.busy;
  assign done                = flags.done;
  assign error               = flags.error;

  assign xfer       = byte_valid & byte_ready;
  assign words_next = words_loaded + COUNT_WIDTH'(1);

  // In LOAD the word only completes when the SoC reports capture and
  // completion in the same cycle; in WAIT_ACK the ack alone completes it.
  assign word_acked = (state == S_LOAD) ? (rom_loader_load_received & rom_loader_ack)
                                        : rom_loader_ack;

  // NOTE: the state and the output flags are updated together with
  // non-blocking assignments, so flags always describe the state just
  // entered and every output is a flop, with no combinational path from
  // inputs to outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_IDLE;
      flags           <= flags_for(S_IDLE);
      rom_loader_data <= '0;
      words_loaded    <= '0;
      count_latched   <= '0;
      timer           <= '0;
      hold_cnt        <= '0;
    end else begin
      unique case (state)
        // Idle-type states: only start leaves them; stray handshake and
        // byte traffic is ignored.
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            count_latched <= word_count;
            words_loaded  <= '0;
            state         <= S_LDR_RST;
            flags         <= flags_for(S_LDR_RST);
          end
        end

        // rom_loader_reset is high for exactly this one cycle.
        S_LDR_RST: begin
          if (count_latched == '0) begin
            hold_cnt <= '0;
            state    <= S_RELEASE;
            flags    <= flags_for(S_RELEASE);
          end else begin
            state <= S_GET_HI;
            flags <= flags_for(S_GET_HI);
          end
        end

        S_GET_HI: begin
          if (xfer) begin
            rom_loader_data[DATA_WIDTH-1 -: 8] <= byte_in;
            state                              <= S_GET_LO;
            flags                              <= flags_for(S_GET_LO);
          end
        end

        S_GET_LO: begin
          if (xfer) begin
            rom_loader_data[7:0] <= byte_in;
            timer                <= '0;
            state                <= S_LOAD;
            flags                <= flags_for(S_LOAD);
          end
        end

        // One watchdog covers the request and the wait for completion.
        // A completion in the last allowed cycle still wins over the timeout.
        S_LOAD, S_WAIT_ACK: begin
          if (word_acked) begin
            words_loaded <= words_next;
            if (words_next == count_latched) begin
              hold_cnt <= '0;
              state    <= S_RELEASE;
              flags    <= flags_for(S_RELEASE);
            end else begin
              state <= S_GET_HI;
              flags <= flags_for(S_GET_HI);
            end
          end else if (timer == TMR_LAST) begin
            state <= S_ERROR;
            flags <= flags_for(S_ERROR);
          end else begin
            timer <= timer + 1'b1;
            if (state == S_LOAD && rom_loader_load_received) begin
              state <= S_WAIT_ACK;
              flags <= flags_for(S_WAIT_ACK);
            end
          end
        end

        // Keep the CPU in reset RELEASE_HOLD cycles after the last ack so
        // the final ROM write has settled before the first fetch.
        S_RELEASE: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= S_DONE;
            flags <= flags_for(S_DONE);
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          flags <= flags_for(S_IDLE);
        end
      endcase
    end
  end

endmodule
